memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Shares the single-ported RAM between the instruction fetch path (iREN) and the data path (dREN/dWEN), sitting between the pipeline's memory-request signals and the RAM model. It is a registered FSM that grants one requester at a time and holds the RAM command stable until the RAM acknowledges. It returns a one-cycle ihit/dhit with registered load data. Data accesses have priority, with a bounded-starvation override for fetch, and a watchdog aborts hung RAM transactions.

## Interface
Parameters:
- STARVE_LIMIT, 4: maximum consecutive data grants while iREN is pending before fetch is forced.
- TIMEOUT, 64: maximum cycles in a busy state without ram_ready before abort.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- iREN  in  1  instruction read request; held until ihit.
- iaddr  in  32  instruction address.
- dREN  in  1  data read request; held until dhit.
- dWEN  in  1  data write request; held until dhit.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- ram_ready  in  1  RAM acknowledge; valid only while ram_ren or ram_wen is high.
- ram_load  in  32  RAM read data; valid with ram_ready.
- ram_ren  out  1  RAM read strobe.
- ram_wen  out  1  RAM write strobe.
- ram_addr  out  32  RAM address.
- ram_store  out  32  RAM write data.
- ihit  out  1  one-cycle instruction completion.
- dhit  out  1  one-cycle data completion.
- iload  out  32  registered instruction word, valid with ihit.
- dload  out  32  registered read data, valid with dhit (0 for writes).
- err  out  1  sticky timeout flag.

## Operation
- States: IDLE, IBUSY, DBUSY, IRESP, DRESP.
- IDLE: no RAM strobes.
  - Arbitrate the current-cycle requests. A data request is dREN|dWEN.
  - Data only goes to DBUSY. Fetch only goes to IBUSY.
  - When both are requesting, go to DBUSY, unless streak == STARVE_LIMIT, in which case go to IBUSY.
  - With no request, stay in IDLE.
- On grant, latch the transaction:
  - the address (iaddr or daddr);
  - the kind: read, or write if dWEN (dWEN wins over dREN);
  - dstore.
- Starvation counter streak, width $clog2(STARVE_LIMIT+1):
  - Increments on a data grant made while iREN is high, saturating at STARVE_LIMIT.
  - Clears on any instruction grant.
  - Holds otherwise.
- IBUSY/DBUSY:
  - Drive ram_ren or ram_wen, plus ram_addr and ram_store, from the latched registers only. They are stable for the whole busy period regardless of input changes.
  - wcnt counts busy cycles.
  - On ram_ready: capture ram_load into iload or dload (dload captures 0 for a write) and go to the matching RESP state.
  - If wcnt == TIMEOUT-1 without ram_ready: set err, load 0, and go to RESP (abort).
- IRESP/DRESP:
  - Assert ihit or dhit for exactly this cycle. No RAM strobes.
  - Clear wcnt and go to IDLE unconditionally.
  - Requests present during RESP are not arbitrated until IDLE.
- Only one of ihit/dhit is ever high. They are never high together with ram_ren/ram_wen.
- err is cleared only by RST.

## Timing
- Reset values:
  - state=IDLE, streak=0, wcnt=0, err=0.
  - ihit=dhit=0, iload=dload=0.
  - ram_ren=ram_wen=0, ram_addr=ram_store=0.
- Reset mid-transaction: the strobes drop in the cycle after the RST edge, and the in-flight access is discarded with no hit.
- Latency:
  - Request seen in IDLE at cycle N: strobe from cycle N+1.
  - ram_ready at cycle N+1+k gives the hit at cycle N+2+k.
  - Minimum request-to-hit is 2 cycles; minimum spacing between back-to-back grants is 3 cycles.
- ram_ready outside a busy state is ignored.
- Timeout: strobe held for exactly TIMEOUT cycles, then RESP with err=1 on the same edge.
- The requester dropping its request mid-busy does not cancel the access; the hit is still issued.
- All outputs are registered or decoded from the state and latched registers. There is no combinational path from the request inputs to the RAM outputs.

## Test plan
- Single fetch:
  - Stimulus: iREN=1, iaddr=0x40, ram_ready one cycle after ram_ren, ram_load=0x8C220004.
  - Required: ihit at cycle 3, iload=0x8C220004, ram_addr=0x40 throughout IBUSY.
- Write precedence:
  - Stimulus: dREN=dWEN=1, daddr=0x100, dstore=0xCAFEF00D, ram_ready after 3 wait cycles.
  - Required: ram_wen=1, ram_ren=0 for 4 cycles; dhit with dload=0.
- Contention and starvation (STARVE_LIMIT=4):
  - Stimulus: iREN and data requests both held high.
  - Required grant sequence: D,D,D,D,I,D,D,D,D,I; streak returns to 0 after each I.
- Timeout (TIMEOUT=8):
  - Stimulus: ram_ready never asserted.
  - Required: ram_ren high for exactly 8 cycles, then dhit with dload=0 and err=1 sticky through later good transactions.
- Reset mid-busy:
  - Stimulus: RST asserted at the second DBUSY cycle.
  - Required: next cycle all outputs are at reset values, no dhit; a following fetch completes normally.
- Input change during busy:
  - Stimulus: daddr changes and dREN drops while in DBUSY.
  - Required: ram_addr stays at the latched value and dhit is still issued once.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Pipeline request/hit signals and RAM command/acknowledge signals seen by the memory arbiter.
interface memory_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        ram_ready;
    logic [31:0] ram_load;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic        ihit;
    logic        dhit;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_ready, ram_load,
        output ram_ren, ram_wen, ram_addr, ram_store, ihit, dhit, iload, dload, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_ready, ram_load,
        input  ram_ren, ram_wen, ram_addr, ram_store, ihit, dhit, iload, dload, err
    );
endinterface

// File: rtl/memory_arbiter.sv
// Shares one RAM port between fetch and data, data first with bounded fetch starvation; request-to-hit >= 2 cycles.
// Requesters hold requests until their one-cycle hit; the RAM command is held until ram_ready or a watchdog abort.
module memory_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic            CLK,
    input  logic            RST,
    memory_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WCNT_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, IBUSY, DBUSY, IRESP, DRESP} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_addr;
    logic [31:0]   r_store;
    logic [31:0]   r_iload;
    logic [31:0]   r_dload;
    logic          r_wr;
    logic          r_err;
    logic [SW-1:0] r_streak;
    logic [WW-1:0] r_wcnt;

    logic w_dreq;
    logic w_grant_d;
    logic w_grant_i;
    logic w_busy;
    logic w_done;

    assign w_dreq    = bus.dREN | bus.dWEN;
    assign w_grant_d = (r_state == IDLE) && w_dreq && !(bus.iREN && (r_streak == STREAK_MAX));
    assign w_grant_i = (r_state == IDLE) && bus.iREN && !w_grant_d;
    assign w_busy    = (r_state == IBUSY) || (r_state == DBUSY);
    assign w_done    = w_busy && (bus.ram_ready || (r_wcnt == WCNT_LAST));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_next = DBUSY;
                end else if (w_grant_i) begin
                    w_next = IBUSY;
                end
            end
            IBUSY:   if (w_done) w_next = IRESP;
            DBUSY:   if (w_done) w_next = DRESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_addr   <= '0;
            r_store  <= '0;
            r_wr     <= 1'b0;
            r_iload  <= '0;
            r_dload  <= '0;
            r_err    <= 1'b0;
            r_streak <= '0;
            r_wcnt   <= '0;
        end else begin
            if (w_grant_d || w_grant_i) begin
                r_addr  <= w_grant_d ? bus.daddr : bus.iaddr;
                r_wr    <= w_grant_d && bus.dWEN;
                r_store <= bus.dstore;
            end
            // Saturation is implicit: a data grant over a pending fetch cannot happen at the limit.
            if (w_grant_i) begin
                r_streak <= '0;
            end else if (w_grant_d && bus.iREN) begin
                r_streak <= r_streak + SW'(1);
            end
            if (w_busy) begin
                if (bus.ram_ready) begin
                    if (r_state == IBUSY) r_iload <= bus.ram_load;
                    else                  r_dload <= r_wr ? '0 : bus.ram_load;
                end else if (r_wcnt == WCNT_LAST) begin
                    r_err <= 1'b1;
                    if (r_state == IBUSY) r_iload <= '0;
                    else                  r_dload <= '0;
                end else begin
                    r_wcnt <= r_wcnt + WW'(1);
                end
            end else if ((r_state == IRESP) || (r_state == DRESP)) begin
                r_wcnt <= '0;
            end
        end
    end

    always_comb begin
        bus.ram_ren   = w_busy && !r_wr;
        bus.ram_wen   = w_busy && r_wr;
        bus.ram_addr  = r_addr;
        bus.ram_store = r_store;
        bus.ihit      = (r_state == IRESP);
        bus.dhit      = (r_state == DRESP);
        bus.iload     = r_iload;
        bus.dload     = r_dload;
        bus.err       = r_err;
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Transaction-level bench for memory_arbiter: directed scenarios plus random traffic against a reference model.
module tb_memory_arbiter;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    memory_arbiter_if bus ();

    memory_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [logic [31:0]];
    bit          in_busy, hit_due, hit_is_i, txn_i, txn_wr, err_m, prev_idle;
    bit          i_done, d_done, auto_req, hold_both, churn;
    int          bcnt, lat, lat_sel, streak_m, hits_i, hits_d, ren_cnt, wen_cnt;
    logic [31:0] txn_addr, txn_store, hit_data;
    bit          grant_log [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic new_fetch();
        bus.iREN  = 1'b1;
        bus.iaddr = 32'($urandom_range(0, 255)) << 2;
    endtask

    task automatic new_data();
        int k;
        k          = $urandom_range(0, 2);
        bus.dREN   = (k != 1);
        bus.dWEN   = (k != 0);
        bus.daddr  = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
        bus.dstore = $urandom;
    endtask

    // One clock: sample and check the cycle just entered, then drive RAM response and requests.
    task automatic step();
        logic strobe, any_req, want, d_first;
        @(posedge CLK);
        #1;
        strobe  = bus.ram_ren | bus.ram_wen;
        any_req = bus.iREN | bus.dREN | bus.dWEN;
        if (bus.ram_ren) ren_cnt++;
        if (bus.ram_wen) wen_cnt++;
        check_eq("exclusive", 32'({bus.ihit & bus.dhit, (bus.ihit | bus.dhit) & strobe,
                                   bus.ram_ren & bus.ram_wen}), 32'd0);
        if (hit_due) begin
            check_eq("hit_kind", 32'({bus.ihit, bus.dhit}), hit_is_i ? 32'd2 : 32'd1);
            check_eq(hit_is_i ? "iload" : "dload", hit_is_i ? bus.iload : bus.dload, hit_data);
            if (hit_is_i) begin hits_i++; i_done = 1'b1; end
            else          begin hits_d++; d_done = 1'b1; end
            hit_due = 1'b0;
            in_busy = 1'b0;
        end else begin
            check_eq("spurious_hit", 32'({bus.ihit, bus.dhit}), 32'd0);
        end
        check_eq("err", 32'(bus.err), 32'(err_m));
        if (!in_busy) begin
            want = prev_idle && any_req;
            check_eq("grant", 32'(strobe), 32'(want));
            if (strobe && want) begin
                d_first   = (bus.dREN | bus.dWEN) && !(bus.iREN && streak_m == STARVE_LIMIT);
                txn_i     = !d_first;
                txn_addr  = txn_i ? bus.iaddr : bus.daddr;
                txn_wr    = !txn_i && bus.dWEN;
                txn_store = bus.dstore;
                if (txn_i) streak_m = 0;
                else if (bus.iREN) streak_m = (streak_m < STARVE_LIMIT) ? streak_m + 1 : STARVE_LIMIT;
                grant_log.push_back(txn_i);
                in_busy = 1'b1;
                bcnt    = 0;
                lat     = (lat_sel >= 0) ? lat_sel :
                          (($urandom_range(0, 11) == 0) ? TIMEOUT + 3 : $urandom_range(0, 3));
            end
        end
        if (in_busy) begin
            bcnt++;
            check_eq("strobe_held", 32'(strobe), 32'd1);
            check_eq("ram_addr", bus.ram_addr, txn_addr);
            check_eq("ram_kind", 32'({bus.ram_ren, bus.ram_wen}), txn_wr ? 32'd1 : 32'd2);
            check_eq("ram_store", bus.ram_store, txn_store);
        end
        prev_idle = !strobe && !(bus.ihit | bus.dhit);

        bus.ram_ready = 1'b0;
        bus.ram_load  = $urandom;
        if (in_busy) begin
            if (bcnt - 1 == lat) begin
                bus.ram_ready = 1'b1;
                hit_data      = txn_wr ? 32'd0 : ram_word(txn_addr);
                if (txn_wr) mem[txn_addr] = txn_store;
                else        bus.ram_load = ram_word(bus.ram_addr);
                hit_due  = 1'b1;
                hit_is_i = txn_i;
            end else if (bcnt == TIMEOUT) begin
                hit_data = 32'd0;
                hit_due  = 1'b1;
                hit_is_i = txn_i;
                err_m    = 1'b1;
            end
        end else begin
            bus.ram_ready = 1'($urandom_range(0, 1));
        end

        if (i_done) begin bus.iREN = 1'b0; i_done = 1'b0; end
        if (d_done) begin bus.dREN = 1'b0; bus.dWEN = 1'b0; d_done = 1'b0; end
        if (churn && in_busy && $urandom_range(0, 5) == 0) begin
            if (txn_i) begin
                bus.iaddr = $urandom;
                bus.iREN  = 1'($urandom_range(0, 1));
            end else begin
                bus.daddr  = $urandom;
                bus.dstore = $urandom;
                bus.dREN   = 1'b0;
                bus.dWEN   = 1'($urandom_range(0, 1));
            end
        end
        if ((auto_req || hold_both) && !bus.iREN && !(in_busy && txn_i) &&
            (hold_both || $urandom_range(0, 3) == 0)) new_fetch();
        if ((auto_req || hold_both) && !(bus.dREN | bus.dWEN) && !(in_busy && !txn_i) &&
            (hold_both || $urandom_range(0, 3) == 0)) new_data();
    endtask

    task automatic run_until_hits(input int want_i, input int want_d, input int budget, output int cycles);
        cycles = 0;
        while ((hits_i < want_i || hits_d < want_d) && cycles < budget) begin
            step();
            cycles++;
        end
        check_eq("hit_wait_budget", 32'(hits_i >= want_i && hits_d >= want_d), 32'd1);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((bus.iREN || bus.dREN || bus.dWEN || in_busy || hit_due) && n < budget) begin
            step();
            n++;
        end
        check_eq("drain_budget", 32'(bus.iREN || bus.dREN || bus.dWEN || in_busy || hit_due), 32'd0);
    endtask

    task automatic apply_reset();
        RST           = 1'b1;
        bus.iREN      = 1'b0;
        bus.dREN      = 1'b0;
        bus.dWEN      = 1'b0;
        bus.ram_ready = 1'b0;
        @(posedge CLK);
        #1;
        check_eq("rst_flags", 32'({bus.ram_ren, bus.ram_wen, bus.ihit, bus.dhit, bus.err}), 32'd0);
        check_eq("rst_ram_addr", bus.ram_addr, 32'd0);
        check_eq("rst_ram_store", bus.ram_store, 32'd0);
        check_eq("rst_iload", bus.iload, 32'd0);
        check_eq("rst_dload", bus.dload, 32'd0);
        RST       = 1'b0;
        in_busy   = 1'b0;
        hit_due   = 1'b0;
        err_m     = 1'b0;
        streak_m  = 0;
        prev_idle = 1'b1;
        i_done    = 1'b0;
        d_done    = 1'b0;
    endtask

    initial begin
        int n;
        int base_d;
        bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
        bus.daddr = '0; bus.dstore = '0; bus.ram_ready = 1'b0; bus.ram_load = '0;
        lat_sel = -1; auto_req = 1'b0; hold_both = 1'b0; churn = 1'b0;
        hits_i = 0; hits_d = 0; ren_cnt = 0; wen_cnt = 0;
        apply_reset();

        // Single fetch, RAM answers in the first strobe cycle.
        mem[32'h40] = 32'h8C22_0004;
        lat_sel  = 0;
        bus.iREN = 1'b1; bus.iaddr = 32'h40;
        run_until_hits(hits_i + 1, hits_d, 20, n);
        check_eq("fetch_latency", 32'(n), 32'd2);
        check_eq("fetch_iload", bus.iload, 32'h8C22_0004);

        // dREN and dWEN together: write wins, four strobe cycles.
        ren_cnt = 0; wen_cnt = 0; lat_sel = 3;
        bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hCAFE_F00D;
        run_until_hits(hits_i, hits_d + 1, 20, n);
        check_eq("wr_wen_cycles", 32'(wen_cnt), 32'd4);
        check_eq("wr_ren_cycles", 32'(ren_cnt), 32'd0);
        check_eq("wr_dload", bus.dload, 32'd0);
        lat_sel = 1;
        bus.dREN = 1'b1; bus.daddr = 32'h100;
        run_until_hits(hits_i, hits_d + 1, 20, n);
        check_eq("wr_readback", bus.dload, 32'hCAFE_F00D);

        // Watchdog abort, then err stays set through a good fetch.
        ren_cnt = 0; lat_sel = 1000;
        bus.dREN = 1'b1; bus.daddr = 32'h104;
        run_until_hits(hits_i, hits_d + 1, 40, n);
        check_eq("to_ren_cycles", 32'(ren_cnt), 32'(TIMEOUT));
        check_eq("to_dload", bus.dload, 32'd0);
        check_eq("to_err", 32'(bus.err), 32'd1);
        lat_sel = 2;
        bus.iREN = 1'b1; bus.iaddr = 32'h44;
        run_until_hits(hits_i + 1, hits_d, 20, n);
        check_eq("err_sticky", 32'(bus.err), 32'd1);

        // Both requesters held: fetch forced after STARVE_LIMIT data grants.
        grant_log.delete();
        lat_sel = -1; hold_both = 1'b1;
        new_fetch(); new_data();
        n = 0;
        while (grant_log.size() < 10 && n < 600) begin step(); n++; end
        hold_both = 1'b0;
        for (int g = 0; g < 10; g++)
            check_eq("contention_grant", (g < grant_log.size()) ? 32'(grant_log[g]) : 32'd2,
                     32'(g % 5 == STARVE_LIMIT));
        drain(200);

        // Address change and request drop mid-busy: access completes once at the latched address.
        lat_sel = 4; base_d = hits_d;
        bus.dREN = 1'b1; bus.daddr = 32'h200;
        n = 0;
        while (!in_busy && n < 10) begin step(); n++; end
        bus.daddr = 32'h300; bus.dREN = 1'b0;
        run_until_hits(hits_i, base_d + 1, 20, n);
        repeat (6) step();
        check_eq("chg_single_dhit", 32'(hits_d - base_d), 32'd1);

        // Reset in the second busy cycle discards the access.
        lat_sel = 1000; base_d = hits_d;
        bus.dREN = 1'b1; bus.daddr = 32'h400;
        n = 0;
        while (!(in_busy && bcnt == 2) && n < 20) begin step(); n++; end
        apply_reset();
        lat_sel = 1;
        bus.iREN = 1'b1; bus.iaddr = 32'h48;
        run_until_hits(hits_i + 1, hits_d, 20, n);
        check_eq("post_rst_fetch_latency", 32'(n), 32'd3);
        check_eq("rst_no_dhit", 32'(hits_d - base_d), 32'd0);

        // Random traffic with mid-busy churn and occasional timeouts.
        lat_sel = -1; auto_req = 1'b1; churn = 1'b1;
        repeat (3000) step();
        auto_req = 1'b0; churn = 1'b0;
        drain(300);
        check_eq("random_progress", 32'(hits_i > 50 && hits_d > 50), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
